// File: rtl/hpu_pkg.sv
// Shared types and defaults for the execution-stage sequencer.
// Combinational content only, so latency and backpressure do not apply.
package hpu_pkg;

  localparam int NUM_ITEMS_DEF = 8;
  localparam int MAX_OUT_DEF   = 2;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_SRC,
    INIT,
    KINIT,
    KRUN,
    KFIN,
    STALL,
    DRAIN,
    DONE
  } exe_sched_state_t;

  // Index width that stays legal when a count of 1 would give $clog2 == 0.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exe_sched_if.sv
// Control and status bundle between source-load logic, exe_sched and the out datapath.
// Wires only: no latency; credit flow is handled inside exe_sched.
interface exe_sched_if #(
  parameter int K_W    = 6,
  parameter int ITEM_W = 3
);

  logic              run;
  logic              src_ready;
  logic [K_W-1:0]    k_len;
  logic              out_busy;
  logic              out_fin;

  logic              s_init;
  logic              k_init;
  logic              k_fin;
  logic              k_en;
  logic [K_W-1:0]    k_idx;
  logic [ITEM_W-1:0] item_idx;
  logic              busy;
  logic              done;
  logic              proto_err;

  modport master (
    output run, src_ready, k_len, out_busy, out_fin,
    input  s_init, k_init, k_fin, k_en, k_idx, item_idx, busy, done, proto_err
  );

  modport slave (
    input  run, src_ready, k_len, out_busy, out_fin,
    output s_init, k_init, k_fin, k_en, k_idx, item_idx, busy, done, proto_err
  );

endinterface

// File: rtl/agu.sv
// Address generator: counts ini..fin once per start pulse, flagging the final step with last.
// Latency: first index the cycle after start; pauses while en is low.
module agu #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic [W-1:0] ini,
  input  logic [W-1:0] fin,
  output logic [W-1:0] idx,
  output logic         last
);

  logic active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      idx    <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx    <= ini;
    end else if (en && active) begin
      if (idx == fin) begin
        active <= 1'b0;
        idx    <= ini;
      end else begin
        idx <= idx + W'(1);
      end
    end
  end

  assign last = active && (idx == fin);

endmodule

// File: rtl/exe_sched.sv
// Execution-stage sequencer: s_init, then per item a k_init / k_en burst / k_fin, then done.
// Latency: s_init 1 cycle after src_ready seen; k-loops stall while MAX_OUT items await out_fin.
module exe_sched
  import hpu_pkg::*;
#(
  parameter int NUM_ITEMS = NUM_ITEMS_DEF,
  parameter int K_W       = 6,
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  exe_sched_if.slave   io
);

  localparam int ITEM_W = idx_w(NUM_ITEMS);
  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(NUM_ITEMS - 1);
  localparam logic [OUT_W-1:0]  MAX_OUT_V = OUT_W'(MAX_OUT);

  exe_sched_state_t  state, nxt;
  logic [K_W-1:0]    kl;
  logic [ITEM_W-1:0] item_idx;
  logic [OUT_W-1:0]  outstanding, out_next;
  logic              proto_err;
  logic [K_W-1:0]    agu_idx;
  logic              agu_last;
  logic              kfin_w;
  logic              unused_out_busy;

  assign unused_out_busy = io.out_busy;
  assign kfin_w          = (state == KFIN);

  // A k_fin and out_fin in the same cycle cancel; out_fin with nothing outstanding saturates at 0.
  always_comb begin
    out_next = outstanding;
    if (kfin_w && !io.out_fin)
      out_next = outstanding + OUT_W'(1);
    else if (!kfin_w && io.out_fin && (outstanding != '0))
      out_next = outstanding - OUT_W'(1);
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (io.run) nxt = WAIT_SRC;
      WAIT_SRC: if (io.src_ready) nxt = INIT;
      INIT:     nxt = KINIT;
      KINIT:    nxt = KRUN;
      KRUN:     if (agu_last) nxt = KFIN;
      KFIN: begin
        if (item_idx == LAST_ITEM)   nxt = DRAIN;
        else if (out_next < MAX_OUT_V) nxt = KINIT;
        else                         nxt = STALL;
      end
      STALL:    if (out_next < MAX_OUT_V) nxt = KINIT;
      DRAIN:    if (out_next == '0) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      kl          <= '0;
      item_idx    <= '0;
      outstanding <= '0;
      proto_err   <= 1'b0;
    end else begin
      state       <= nxt;
      outstanding <= out_next;
      if (io.out_fin && (outstanding == '0))
        proto_err <= 1'b1;
      if (state == INIT) begin
        kl       <= (io.k_len == '0) ? K_W'(1) : io.k_len;
        item_idx <= '0;
      end
      if (kfin_w && (item_idx != LAST_ITEM))
        item_idx <= item_idx + ITEM_W'(1);
    end
  end

  agu #(.W(K_W)) u_agu (
    .clk   (clk),
    .rst   (rst),
    .start (state == KINIT),
    .en    (1'b1),
    .ini   ('0),
    .fin   (kl - K_W'(1)),
    .idx   (agu_idx),
    .last  (agu_last)
  );

  assign io.s_init    = (state == INIT);
  assign io.k_init    = (state == KINIT);
  assign io.k_en      = (state == KRUN);
  assign io.k_fin     = kfin_w;
  assign io.k_idx     = (state == KRUN) ? agu_idx : '0;
  assign io.item_idx  = item_idx;
  assign io.busy      = (state != IDLE);
  assign io.done      = (state == DONE);
  assign io.proto_err = proto_err;

endmodule

// File: tb/tb_exe_sched.sv
// Directed bench for exe_sched: nominal run, credit stall, coincident credit, k_len corners,
// src_ready hold, ignored run, sticky proto_err and reset mid-KRUN.
module tb_exe_sched;
  import hpu_pkg::*;

  localparam int K_W = 6;
  localparam int IW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_sched_if #(.K_W(K_W), .ITEM_W(IW)) io ();

  exe_sched #(.NUM_ITEMS(8), .K_W(K_W), .MAX_OUT(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int total = 0;
  int bad   = 0;
  int s_at, ki_at, done_at, nkf, nken, ns, hold_bad;
  int kf [8];
  logic d1, d2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    io.run       = 1'b0;
    io.src_ready = 1'b0;
    io.k_len     = '0;
    io.out_busy  = 1'b0;
    io.out_fin   = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset;
    chk("rst_flags", {io.s_init, io.k_init, io.k_en, io.k_fin, io.done, io.busy, io.proto_err}, 0);
    chk("rst_cnt", {io.k_idx, io.item_idx, dut.outstanding}, 0);
    chk("rst_state", dut.state, IDLE);

    // Nominal run: k_len=4, out_fin two cycles after each k_fin
    io.k_len = 6'd4; io.src_ready = 1'b1;
    s_at = -1; ki_at = -1; done_at = -1; nkf = 0; nken = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 8; i++) kf[i] = -1;
    for (int c = 0; c < 60; c++) begin
      io.run     = (c == 0);
      io.out_fin = d2;
      if (io.s_init && s_at < 0) s_at = c;
      if (io.k_init && ki_at < 0) ki_at = c;
      if (io.k_en) nken++;
      if (io.k_fin) begin
        if (nkf < 8) kf[nkf] = c;
        nkf++;
      end
      if (io.done && done_at < 0) done_at = c;
      if (c >= 4 && c <= 7) chk("basic_k_idx", io.k_idx, c - 4);
      if (c == 54) chk("basic_idle_after_done", io.busy, 0);
      d2 = d1; d1 = io.k_fin;
      tick;
    end
    io.run = 1'b0; io.out_fin = 1'b0;
    chk("basic_s_init_cycle", s_at, 2);
    chk("basic_k_init_cycle", ki_at, 3);
    chk("basic_kfin_count", nkf, 8);
    for (int i = 0; i < 8; i++) chk("basic_kfin_cycle", kf[i], 8 + 6 * i);
    chk("basic_ken_cycles", nken, 32);
    chk("basic_done_cycle", done_at, 53);
    chk("basic_proto_err", io.proto_err, 0);

    // Credit stall: no out_fin until cycle 35
    do_reset;
    io.k_len = 6'd4; io.src_ready = 1'b1; nkf = 0;
    for (int c = 0; c <= 36; c++) begin
      io.run     = (c == 0);
      io.out_fin = (c == 35);
      if (io.k_fin) nkf++;
      if (c == 34) begin
        chk("stall_busy_ken_kinit", {io.busy, io.k_en, io.k_init}, 3'b100);
        chk("stall_outstanding", dut.outstanding, 2);
        chk("stall_state", dut.state, STALL);
      end
      if (c == 35) chk("stall_no_early_kinit", io.k_init, 0);
      if (c == 36) chk("stall_release_kinit", io.k_init, 1);
      tick;
    end
    io.out_fin = 1'b0;
    chk("stall_kfin_count", nkf, 2);

    // out_fin coinciding with the second k_fin avoids the stall
    do_reset;
    io.k_len = 6'd4; io.src_ready = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      io.run     = (c == 0);
      io.out_fin = (c == 14);
      if (c == 14) chk("sim_kfin", io.k_fin, 1);
      if (c == 15) begin
        chk("sim_kinit_next", io.k_init, 1);
        chk("sim_outstanding", dut.outstanding, 1);
      end
      if (c == 21) chk("sim_third_kfin_stalls", dut.state, STALL);
      tick;
    end
    io.out_fin = 1'b0;
    chk("sim_proto_err", io.proto_err, 0);

    // k_len=0 acts as 1; a later k_len change does not affect the run
    do_reset;
    io.k_len = 6'd0; io.src_ready = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      io.run = (c == 0);
      if (c == 4) begin
        io.k_len = 6'd3;
        chk("kl0_ken_kidx", {io.k_en, io.k_idx}, {1'b1, 6'd0});
      end
      if (c == 5) chk("kl0_kfin", {io.k_en, io.k_fin}, 2'b01);
      if (c == 8) chk("klchg_kfin", io.k_fin, 1);
      tick;
    end

    // src_ready low holds WAIT_SRC; run mid-run is ignored
    do_reset;
    io.k_len = 6'd2; ns = 0; hold_bad = 0; d1 = 0; d2 = 0;
    for (int c = 0; c <= 21; c++) begin
      io.run       = (c == 0 || c == 18);
      io.src_ready = (c >= 11);
      io.out_fin   = d2;
      if (c >= 1 && c <= 10 && (io.s_init || !io.busy)) hold_bad++;
      if (io.s_init) ns++;
      if (c == 12) chk("src_s_init", io.s_init, 1);
      if (c == 21) begin
        chk("run_ignored_item_idx", io.item_idx, 2);
        chk("run_ignored_kinit", io.k_init, 1);
      end
      d2 = d1; d1 = io.k_fin;
      tick;
    end
    io.out_fin = 1'b0;
    chk("src_hold", hold_bad, 0);
    chk("s_init_once", ns, 1);

    // Spurious out_fin in IDLE, then reset mid-KRUN
    do_reset;
    io.k_len = 6'd4; io.src_ready = 1'b1;
    io.out_fin = 1'b1;
    tick;
    io.out_fin = 1'b0;
    chk("proto_set_idle", {io.proto_err, io.busy}, 2'b10);
    tick; tick;
    io.run = 1'b1;
    tick;
    io.run = 1'b0;
    repeat (5) tick;
    chk("mid_krun_kidx", {io.k_en, io.k_idx}, {1'b1, 6'd2});
    chk("proto_sticky", io.proto_err, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_flags", {io.s_init, io.k_init, io.k_en, io.k_fin, io.done, io.busy, io.proto_err}, 0);
    chk("rst_mid_cnt", {io.k_idx, io.item_idx, dut.outstanding}, 0);
    chk("rst_mid_state", dut.state, IDLE);
    for (int c = 0; c <= 8; c++) begin
      io.run = (c == 0);
      if (c == 2) chk("rerun_s_init", io.s_init, 1);
      if (c == 3) chk("rerun_k_init", io.k_init, 1);
      if (c == 8) chk("rerun_k_fin", io.k_fin, 1);
      tick;
    end
    io.run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
